// File: rtl/mc_maindec_pkg.sv
// Shared types and constants for the multi-cycle main decoder.
// Contents: FSM state enum, opcode-class enum, opcode match patterns (value/mask pairs,
// mask bit 0 = don't care), ALUOp encodings and the opcode match helper.
package mc_maindec_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    typedef enum logic [3:0] {
        OcNop,
        OcR,
        OcLdur,
        OcStur,
        OcCbz,
        OcCbnz,
        OcB,
        OcAddi,
        OcSubi
    } opclass_e;

    typedef struct packed {
        logic [10:0] val;
        logic [10:0] mask;
    } op_pat_t;

    // Base set
    localparam op_pat_t PatLdur  = '{val: 11'b11111000010, mask: 11'b11111111111};
    localparam op_pat_t PatStur  = '{val: 11'b11111000000, mask: 11'b11111111111};
    localparam op_pat_t PatCbz   = '{val: 11'b10110100000, mask: 11'b11111111000};
    localparam op_pat_t PatAdd   = '{val: 11'b10001011000, mask: 11'b11111111111};
    localparam op_pat_t PatSub   = '{val: 11'b11001011000, mask: 11'b11111111111};
    localparam op_pat_t PatAnd   = '{val: 11'b10001010000, mask: 11'b11111111111};
    localparam op_pat_t PatOrr   = '{val: 11'b10101010000, mask: 11'b11111111111};
    // Extended set
    localparam op_pat_t PatAddi  = '{val: 11'b10010001000, mask: 11'b11111111110};
    localparam op_pat_t PatSubi  = '{val: 11'b11010001000, mask: 11'b11111111110};
    localparam op_pat_t PatCbnz  = '{val: 11'b10110101000, mask: 11'b11111111000};
    localparam op_pat_t PatB     = '{val: 11'b00010100000, mask: 11'b11111100000};

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpPassB = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam int unsigned WaitCntW = 8;

    function automatic logic op_match(input logic [10:0] op, input op_pat_t pat);
        return (op & pat.mask) == pat.val;
    endfunction

endpackage

// File: rtl/mc_maindec_opclass_dec.sv
// Combinational opcode classifier.
// Ports: i_op (instruction[31:21]) -> o_opclass (decoded class, OcNop when unknown),
//        o_illegal (high when the opcode is not in the enabled instruction set).
// EXT_ISA=0 removes ADDI/SUBI/CBNZ/B from the legal set.
module mc_maindec_opclass_dec
    import mc_maindec_pkg::*;
#(
    parameter int unsigned EXT_ISA = 1
) (
    input  logic [10:0] i_op,
    output opclass_e    o_opclass,
    output logic        o_illegal
);

    localparam bit ExtEn = (EXT_ISA != 0);

    opclass_e w_class;

    always_comb begin
        w_class = OcNop;
        if (op_match(i_op, PatLdur)) begin
            w_class = OcLdur;
        end else if (op_match(i_op, PatStur)) begin
            w_class = OcStur;
        end else if (op_match(i_op, PatCbz)) begin
            w_class = OcCbz;
        end else if (op_match(i_op, PatAdd) || op_match(i_op, PatSub) ||
                     op_match(i_op, PatAnd) || op_match(i_op, PatOrr)) begin
            w_class = OcR;
        end else if (ExtEn && op_match(i_op, PatAddi)) begin
            w_class = OcAddi;
        end else if (ExtEn && op_match(i_op, PatSubi)) begin
            w_class = OcSubi;
        end else if (ExtEn && op_match(i_op, PatCbnz)) begin
            w_class = OcCbnz;
        end else if (ExtEn && op_match(i_op, PatB)) begin
            w_class = OcB;
        end
    end

    assign o_opclass = w_class;
    assign o_illegal = (w_class == OcNop);

endmodule

// File: rtl/mc_maindec.sv
// Multi-cycle main decoder: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Inputs : clk, reset (async active-low), instr_valid (FETCH only), Op (DECODE only),
//          mem_ready (MEM only).
// Outputs: IRWrite/PCWrite, datapath controls, BranchNZ/UncondBranch, ALUOp (zero-extended
//          to ALUOP_W), busy (not FETCH), illegal/mem_err (one-cycle pulses in the following
//          FETCH cycle).
module mc_maindec
    import mc_maindec_pkg::*;
#(
    parameter int unsigned EXT_ISA     = 1,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ALUOP_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [10:0]        Op,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               Reg2Loc,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic               BranchNZ,
    output logic               UncondBranch,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               busy,
    output logic               illegal,
    output logic               mem_err
);

    // Last MEM cycle index allowed before the access is abandoned.
    localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(MEM_TIMEOUT - 1);

    state_e              r_state, w_state_d;
    opclass_e            r_opclass, w_opclass_d, w_dec_class;
    logic                w_dec_illegal;
    logic [WaitCntW-1:0] r_wait_cnt, w_wait_cnt_d;
    logic                r_illegal, w_illegal_d;
    logic                r_mem_err, w_mem_err_d;
    logic [1:0]          w_aluop;
    logic                w_is_ld;

    mc_maindec_opclass_dec #(
        .EXT_ISA (EXT_ISA)
    ) u_opclass_dec (
        .i_op      (Op),
        .o_opclass (w_dec_class),
        .o_illegal (w_dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StFetch;
            r_opclass  <= OcNop;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_opclass  <= w_opclass_d;
            r_wait_cnt <= w_wait_cnt_d;
            r_illegal  <= w_illegal_d;
            r_mem_err  <= w_mem_err_d;
        end
    end

    assign w_is_ld = (r_opclass == OcLdur);

    always_comb begin
        w_state_d    = r_state;
        w_opclass_d  = r_opclass;
        w_wait_cnt_d = r_wait_cnt;
        w_illegal_d  = 1'b0;
        w_mem_err_d  = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        Reg2Loc      = 1'b0;
        ALUSrc       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Branch       = 1'b0;
        BranchNZ     = 1'b0;
        UncondBranch = 1'b0;
        w_aluop      = AluOpAdd;
        busy         = 1'b0;
        // Outputs are forced low while reset is held, independent of any clock edge.
        if (reset) begin
            unique case (r_state)
                StFetch: begin
                    if (instr_valid) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        w_state_d = StDecode;
                    end
                end
                StDecode: begin
                    busy        = 1'b1;
                    w_opclass_d = w_dec_class;
                    if (w_dec_illegal) begin
                        w_illegal_d = 1'b1;
                        w_state_d   = StFetch;
                    end else begin
                        w_state_d = StExec;
                    end
                end
                StExec: begin
                    busy      = 1'b1;
                    w_state_d = StFetch;
                    case (r_opclass)
                        OcR: begin
                            w_aluop   = AluOpFunct;
                            w_state_d = StWb;
                        end
                        OcAddi: begin
                            ALUSrc    = 1'b1;
                            w_state_d = StWb;
                        end
                        OcSubi: begin
                            ALUSrc    = 1'b1;
                            w_aluop   = AluOpFunct;
                            w_state_d = StWb;
                        end
                        OcLdur, OcStur: begin
                            ALUSrc       = 1'b1;
                            Reg2Loc      = (r_opclass == OcStur);
                            w_wait_cnt_d = '0;
                            w_state_d    = StMem;
                        end
                        OcCbz, OcCbnz: begin
                            Reg2Loc  = 1'b1;
                            Branch   = 1'b1;
                            BranchNZ = (r_opclass == OcCbnz);
                            w_aluop  = AluOpPassB;
                        end
                        OcB: UncondBranch = 1'b1;
                        default: ;
                    endcase
                end
                StMem: begin
                    busy     = 1'b1;
                    ALUSrc   = 1'b1;
                    MemRead  = w_is_ld;
                    MemWrite = !w_is_ld;
                    Reg2Loc  = !w_is_ld;
                    // mem_ready wins over the timeout on the final wait cycle.
                    if (mem_ready) begin
                        w_state_d = w_is_ld ? StWb : StFetch;
                    end else if (r_wait_cnt == WaitLast) begin
                        w_mem_err_d = 1'b1;
                        w_state_d   = StFetch;
                    end else begin
                        w_wait_cnt_d = r_wait_cnt + 1'b1;
                    end
                end
                StWb: begin
                    busy      = 1'b1;
                    RegWrite  = 1'b1;
                    MemtoReg  = w_is_ld;
                    w_state_d = StFetch;
                end
                default: w_state_d = StFetch;
            endcase
        end
    end

    assign ALUOp   = ALUOP_W'(w_aluop);
    assign illegal = r_illegal;
    assign mem_err = r_mem_err;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: one instance with the extended ISA (timeout 15, 2-bit ALUOp) and one
// base-only instance (timeout 3, 3-bit ALUOp). Each instruction is expanded into the expected
// per-cycle control trace from the instruction-class rules and compared cycle by cycle.
module tb_mc_maindec;

    localparam int T1 = 15;
    localparam int T0 = 3;

    typedef struct packed {
        logic       irw, pcw, r2l, alusrc, m2r, rw, mrd, mwr, br, bnz, ub;
        logic [1:0] aluop;
        logic       busy, ill, merr;
    } ctl_t;

    typedef enum {KLdur, KStur, KCbz, KCbnz, KB, KR, KAddi, KSubi, KIll} kind_e;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv1, mr1, iv0, mr0;
    logic [10:0] op1, op0;

    logic IRWrite1, PCWrite1, Reg2Loc1, ALUSrc1, MemtoReg1, RegWrite1, MemRead1, MemWrite1;
    logic Branch1, BranchNZ1, UncondBranch1, busy1, illegal1, mem_err1;
    logic [1:0] ALUOp1;
    logic IRWrite0, PCWrite0, Reg2Loc0, ALUSrc0, MemtoReg0, RegWrite0, MemRead0, MemWrite0;
    logic Branch0, BranchNZ0, UncondBranch0, busy0, illegal0, mem_err0;
    logic [2:0] ALUOp0;

    ctl_t obs1, obs0;
    int   checks = 0;
    int   failures = 0;

    logic [10:0] pat_base [12] = '{11'b11111000010, 11'b11111000000, 11'b10110100000,
                                   11'b10001011000, 11'b11001011000, 11'b10001010000,
                                   11'b10101010000, 11'b10010001000, 11'b11010001000,
                                   11'b10110101000, 11'b00010100000, 11'b00000000000};
    logic [10:0] pat_mask [12] = '{11'h000, 11'h000, 11'h007, 11'h000, 11'h000, 11'h000,
                                   11'h000, 11'h001, 11'h001, 11'h007, 11'h01F, 11'h7FF};

    always #5 clk = ~clk;

    mc_maindec #(.EXT_ISA(1), .MEM_TIMEOUT(T1), .ALUOP_W(2)) dut (
        .clk(clk), .reset(reset), .instr_valid(iv1), .Op(op1), .mem_ready(mr1),
        .IRWrite(IRWrite1), .PCWrite(PCWrite1), .Reg2Loc(Reg2Loc1), .ALUSrc(ALUSrc1),
        .MemtoReg(MemtoReg1), .RegWrite(RegWrite1), .MemRead(MemRead1), .MemWrite(MemWrite1),
        .Branch(Branch1), .BranchNZ(BranchNZ1), .UncondBranch(UncondBranch1), .ALUOp(ALUOp1),
        .busy(busy1), .illegal(illegal1), .mem_err(mem_err1)
    );

    mc_maindec #(.EXT_ISA(0), .MEM_TIMEOUT(T0), .ALUOP_W(3)) dut0 (
        .clk(clk), .reset(reset), .instr_valid(iv0), .Op(op0), .mem_ready(mr0),
        .IRWrite(IRWrite0), .PCWrite(PCWrite0), .Reg2Loc(Reg2Loc0), .ALUSrc(ALUSrc0),
        .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .MemRead(MemRead0), .MemWrite(MemWrite0),
        .Branch(Branch0), .BranchNZ(BranchNZ0), .UncondBranch(UncondBranch0), .ALUOp(ALUOp0),
        .busy(busy0), .illegal(illegal0), .mem_err(mem_err0)
    );

    assign obs1 = {IRWrite1, PCWrite1, Reg2Loc1, ALUSrc1, MemtoReg1, RegWrite1, MemRead1,
                   MemWrite1, Branch1, BranchNZ1, UncondBranch1, ALUOp1, busy1, illegal1,
                   mem_err1};
    assign obs0 = {IRWrite0, PCWrite0, Reg2Loc0, ALUSrc0, MemtoReg0, RegWrite0, MemRead0,
                   MemWrite0, Branch0, BranchNZ0, UncondBranch0, ALUOp0[1:0], busy0, illegal0,
                   mem_err0};

    function automatic kind_e classify(input logic [10:0] op, input bit ext);
        if (op == 11'b11111000010) return KLdur;
        if (op == 11'b11111000000) return KStur;
        if (op[10:3] == 8'b10110100) return KCbz;
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return KR;
        if (ext) begin
            if (op[10:1] == 10'b1001000100) return KAddi;
            if (op[10:1] == 10'b1101000100) return KSubi;
            if (op[10:3] == 8'b10110101) return KCbnz;
            if (op[10:5] == 6'b000101) return KB;
        end
        return KIll;
    endfunction

    task automatic check(input bit w, input ctl_t exp, input string tag);
        ctl_t got;
        got = w ? obs1 : obs0;
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
        if (!w) begin
            checks++;
            assert (ALUOp0[2] === 1'b0) else begin
                failures++;
                $error("FAIL %s_aluop_msb observed=%b expected=0", tag, ALUOp0[2]);
            end
        end
    endtask

    // Called at posedge+1; drives inputs, checks at negedge, returns at next posedge+1.
    task automatic step(input bit w, input logic iv, input logic [10:0] op, input logic mr,
                        input ctl_t exp, input string tag);
        if (w) begin
            iv1 = iv; op1 = op; mr1 = mr;
        end else begin
            iv0 = iv; op0 = op; mr0 = mr;
        end
        @(negedge clk);
        check(w, exp, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit w, input logic [10:0] op, input int k);
        kind_e kind;
        ctl_t  e;
        int    t, nwait;
        bit    tmo;
        kind = classify(op, w);
        t    = w ? T1 : T0;
        tmo  = 1'b0;
        e = '0; e.irw = 1'b1; e.pcw = 1'b1;
        step(w, 1'b1, op, 1'($urandom), e, "fetch");
        e = '0; e.busy = 1'b1;
        step(w, 1'($urandom), op, 1'($urandom), e, "decode");
        if (kind == KIll) begin
            e = '0; e.ill = 1'b1;
            step(w, 1'b0, 11'($urandom), 1'($urandom), e, "illegal_pulse");
            return;
        end
        e = '0; e.busy = 1'b1;
        case (kind)
            KR:    e.aluop = 2'b10;
            KAddi: e.alusrc = 1'b1;
            KSubi: begin e.alusrc = 1'b1; e.aluop = 2'b10; end
            KLdur: e.alusrc = 1'b1;
            KStur: begin e.alusrc = 1'b1; e.r2l = 1'b1; end
            KCbz:  begin e.r2l = 1'b1; e.br = 1'b1; e.aluop = 2'b01; end
            KCbnz: begin e.r2l = 1'b1; e.br = 1'b1; e.bnz = 1'b1; e.aluop = 2'b01; end
            KB:    e.ub = 1'b1;
            default: ;
        endcase
        step(w, 1'($urandom), 11'($urandom), 1'($urandom), e, "exec");
        if (kind == KLdur || kind == KStur) begin
            tmo   = !(k >= 0 && k < t);
            nwait = tmo ? t : k + 1;
            for (int i = 0; i < nwait; i++) begin
                e = '0; e.busy = 1'b1; e.alusrc = 1'b1;
                if (kind == KLdur) e.mrd = 1'b1;
                else begin e.mwr = 1'b1; e.r2l = 1'b1; end
                step(w, 1'($urandom), 11'($urandom), (i == k), e, "mem");
            end
        end
        if ((kind == KLdur && !tmo) || kind == KR || kind == KAddi || kind == KSubi) begin
            e = '0; e.busy = 1'b1; e.rw = 1'b1; e.m2r = (kind == KLdur);
            step(w, 1'($urandom), 11'($urandom), 1'($urandom), e, "wb");
        end
        e = '0; e.merr = tmo;
        step(w, 1'b0, 11'($urandom), 1'($urandom), e, "next_fetch");
    endtask

    initial begin
        ctl_t e;
        int   idx, k;
        bit   w;
        logic [10:0] op;

        // Reset acts before any clock edge, even with instr_valid high.
        reset = 1'b0;
        iv1 = 1'b1; iv0 = 1'b1; op1 = '0; op0 = '0; mr1 = 1'b1; mr0 = 1'b1;
        #2;
        check(1'b1, ctl_t'(0), "reset_async_main");
        check(1'b0, ctl_t'(0), "reset_async_base");
        @(negedge clk);
        check(1'b1, ctl_t'(0), "reset_hold_main");
        iv1 = 1'b0; iv0 = 1'b0; mr1 = 1'b0; mr0 = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 11'h000, 1'b1, ctl_t'(0), "idle_main");
        step(1'b0, 1'b0, 11'h000, 1'b1, ctl_t'(0), "idle_base");

        // Directed cases
        run_op(1'b1, 11'b10001011000, -1);   // ADD
        run_op(1'b1, 11'b11111000010, 2);    // LDUR, ready on third MEM cycle
        run_op(1'b1, 11'b11111000000, -1);   // STUR, never ready -> timeout
        run_op(1'b1, 11'b11111000010, T1 - 1); // ready on the timeout cycle
        run_op(1'b0, 11'b10110101000, -1);   // CBNZ illegal on base set
        run_op(1'b1, 11'b10110101000, -1);   // CBNZ legal on extended set
        run_op(1'b1, 11'b00010111111, -1);   // B
        run_op(1'b1, 11'b11010001001, -1);   // SUBI
        run_op(1'b0, 11'b11111000010, T0 - 1);
        run_op(1'b0, 11'b11111000000, T0);   // base timeout of 3
        run_op(1'b0, 11'b10110100111, -1);   // CBZ

        // Reset while an LDUR is waiting in MEM
        e = '0; e.irw = 1'b1; e.pcw = 1'b1;
        step(1'b1, 1'b1, 11'b11111000010, 1'b0, e, "rst_fetch");
        e = '0; e.busy = 1'b1;
        step(1'b1, 1'b0, 11'b11111000010, 1'b0, e, "rst_decode");
        e.alusrc = 1'b1;
        step(1'b1, 1'b0, 11'b11111000010, 1'b0, e, "rst_exec");
        e.mrd = 1'b1;
        step(1'b1, 1'b0, 11'b11111000010, 1'b0, e, "rst_mem");
        reset = 1'b0;
        #1;
        check(1'b1, ctl_t'(0), "rst_mem_async");
        @(negedge clk);
        check(1'b1, ctl_t'(0), "rst_mem_hold");
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, 1'b0, 11'h000, 1'b1, ctl_t'(0), "rst_post_idle");
        run_op(1'b1, 11'b10101010000, -1);

        // Randomized instructions from the opcode pattern table
        for (int n = 0; n < 40; n++) begin
            w   = 1'($urandom);
            idx = int'($urandom_range(0, 11));
            op  = pat_base[idx] | (11'($urandom) & pat_mask[idx]);
            k   = int'($urandom_range(0, (w ? T1 : T0) + 1)) - 1;
            run_op(w, op, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameter EXT_ISA, default 1; 1 = also decode ADDI/SUBI/CBNZ/B, 0 = base set only (LDUR, STUR, CBZ, R-format).
REQ-002 Parameter MEM_TIMEOUT, default 15; max MEM-state wait cycles before abort, range 1..255.
REQ-003 Parameter ALUOP_W, default 2; ALUOp width, values above 2 zero-extended.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = reset).
REQ-006 instr_valid  in  1  instruction word valid in FETCH.
REQ-007 Op  in  11  instruction[31:21], sampled only in DECODE.
REQ-008 mem_ready  in  1  data memory completes access this cycle.
REQ-009 IRWrite, PCWrite  out  1 each  latch instruction / advance PC.
REQ-010 Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
REQ-011 BranchNZ, UncondBranch  out  1 each  CBNZ polarity / B.
REQ-012 ALUOp  out  ALUOP_W  00 add, 01 pass-B/zero-test, 10 R-format funct.
REQ-013 busy  out  1  high in every state except FETCH.
REQ-014 illegal, mem_err  out  1 each  one-cycle error pulses.

Function
REQ-015 States FETCH, DECODE, EXEC, MEM, WB; encoding from package enum.
REQ-016 FETCH: wait for instr_valid; with instr_valid=1 assert IRWrite and PCWrite that cycle, go DECODE.
REQ-017 DECODE: register Op class into opclass_q; illegal opcode -> pulse illegal next cycle, return FETCH, no write strobes.
REQ-018 Decoding (casez): LDUR 11111000010; STUR 11111000000; CBZ 10110100???; R-format 10001011000/11001011000/10001010000/10101010000; EXT_ISA only: ADDI 1001000100?, SUBI 1101000100?, CBNZ 10110101???, B 000101?????.
REQ-019 EXEC controls: R: ALUOp=10; LDUR/STUR/ADDI/SUBI: ALUSrc=1, ALUOp=00 (SUBI ALUOp=10); STUR adds Reg2Loc=1; CBZ: Reg2Loc=1, Branch=1, ALUOp=01; CBNZ as CBZ plus BranchNZ=1; B: UncondBranch=1.
REQ-020 EXEC next: LDUR/STUR -> MEM; R/ADDI/SUBI -> WB; CBZ/CBNZ/B -> FETCH.
REQ-021 MEM: hold MemRead (LDUR) or MemWrite, Reg2Loc=1 (STUR), ALUSrc=1 until mem_ready=1; then LDUR -> WB, STUR -> FETCH.
REQ-022 MEM wait counter: cleared on MEM entry; after MEM_TIMEOUT cycles with mem_ready=0 pulse mem_err, deassert strobes, go FETCH.
REQ-023 mem_ready=1 on the timeout cycle counts as success, no mem_err.
REQ-024 WB: RegWrite=1 one cycle; MemtoReg=1 for LDUR only; next FETCH.
REQ-025 Latency FETCH-accept to next FETCH: R/ADDI/SUBI 4, STUR 4+waits, LDUR 5+waits, branches 3, illegal 2 cycles.
REQ-026 Unlisted outputs 0 in every state; no output glitch-driven from Op except via opclass_q.
REQ-027 instr_valid and mem_ready ignored outside FETCH and MEM respectively.

Reset
REQ-028 reset=0: state FETCH, opclass_q NOP, wait counter 0, all outputs 0, effective immediately.
REQ-029 Reset mid-MEM aborts access with no further strobes; first post-reset cycle is FETCH.

Structure
REQ-030 Package mc_maindec_pkg: state enum, opcode-class enum, opcode casez constants, ALUOp constants.
REQ-031 Sub-module opclass_dec: combinational Op + EXT_ISA -> opcode class, illegal flag.

Verification
REQ-032 Op=10001011000, instr_valid=1 -> IRWrite@c0, ALUOp=10@c2, RegWrite=1 MemtoReg=0@c3, FETCH@c4.
REQ-033 Op=11111000010, mem_ready after 3 MEM cycles -> MemRead high 3 cycles, then RegWrite=1 MemtoReg=1.
REQ-034 Op=11111000000, mem_ready never -> MemWrite high 15 cycles, mem_err pulse, FETCH, no RegWrite.
REQ-035 EXT_ISA=0, Op=10110101000 (CBNZ) -> illegal pulse, no write strobes; EXT_ISA=1 -> Branch=1 BranchNZ=1 in EXEC.
REQ-036 reset=0 asserted in MEM of LDUR -> all outputs 0 same cycle, FETCH after release, busy=0.
